// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory request/response port between the IFU
// (read-only) and the LSU (read/write). One transaction is in flight at a time;
// contention is resolved round-robin.
//
// Ports:
//   clock, reset                      clock, async active-high reset
//   ifu_req_*/ifu_addr_i              IFU read request (valid/ready)
//   ifu_resp_*/ifu_rdata_o            IFU read response (valid/ready)
//   lsu_req_*/lsu_addr/wen/wdata/wmask LSU request (valid/ready)
//   lsu_resp_*/lsu_rdata_o            LSU response, read data or write ack
//   mem_req_*/mem_addr/wen/wdata/wmask memory request (valid/ready)
//   mem_resp_*/mem_rdata_i            memory response (valid/ready)
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | no owner; choose a requester, all handshakes low
// IFU_REQ  | IFU request routed to memory, waiting for mem_req_ready_i
// IFU_RESP | memory response routed to IFU, waiting for the handshake
// LSU_REQ  | LSU request routed to memory, waiting for mem_req_ready_i
// LSU_RESP | memory response routed to LSU, waiting for the handshake
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ifu_req_valid_i,
    output logic                ifu_req_ready_o,
    input  logic [ADDR_W-1:0]   ifu_addr_i,
    output logic                ifu_resp_valid_o,
    input  logic                ifu_resp_ready_i,
    output logic [DATA_W-1:0]   ifu_rdata_o,
    input  logic                lsu_req_valid_i,
    output logic                lsu_req_ready_o,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic                lsu_wen_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    input  logic [DATA_W/8-1:0] lsu_wmask_i,
    output logic                lsu_resp_valid_o,
    input  logic                lsu_resp_ready_i,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wen_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wmask_o,
    input  logic                mem_resp_valid_i,
    output logic                mem_resp_ready_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        IFU_REQ,
        IFU_RESP,
        LSU_REQ,
        LSU_RESP
    } state_t;

    state_t state, state_nxt;
    // 1 when the LSU held the most recent grant; resets to 1 so the IFU wins
    // the first tie.
    logic   last_lsu, last_lsu_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_lsu <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_lsu <= last_lsu_nxt;
        end
    end

    // Every output is a function of the state, so an async reset into IDLE
    // drops all of them in the same cycle.
    always_comb begin
        state_nxt        = state;
        last_lsu_nxt     = last_lsu;
        ifu_req_ready_o  = 1'b0;
        ifu_resp_valid_o = 1'b0;
        ifu_rdata_o      = '0;
        lsu_req_ready_o  = 1'b0;
        lsu_resp_valid_o = 1'b0;
        lsu_rdata_o      = '0;
        mem_req_valid_o  = 1'b0;
        mem_addr_o       = '0;
        mem_wen_o        = 1'b0;
        mem_wdata_o      = '0;
        mem_wmask_o      = '0;
        mem_resp_ready_o = 1'b0;

        case (state)
            IDLE: begin
                // IFU wins when it is alone or when the LSU had the last grant.
                if (ifu_req_valid_i && (!lsu_req_valid_i || last_lsu)) begin
                    state_nxt    = IFU_REQ;
                    last_lsu_nxt = 1'b0;
                end else if (lsu_req_valid_i) begin
                    state_nxt    = LSU_REQ;
                    last_lsu_nxt = 1'b1;
                end
            end
            IFU_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = ifu_addr_i;
                ifu_req_ready_o = mem_req_ready_i;
                if (mem_req_ready_i) state_nxt = IFU_RESP;
            end
            IFU_RESP: begin
                mem_resp_ready_o = ifu_resp_ready_i;
                ifu_resp_valid_o = mem_resp_valid_i;
                ifu_rdata_o      = mem_rdata_i;
                if (mem_resp_valid_i && ifu_resp_ready_i) state_nxt = IDLE;
            end
            LSU_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_addr_o      = lsu_addr_i;
                mem_wen_o       = lsu_wen_i;
                mem_wdata_o     = lsu_wdata_i;
                mem_wmask_o     = lsu_wmask_i;
                lsu_req_ready_o = mem_req_ready_i;
                if (mem_req_ready_i) state_nxt = LSU_RESP;
            end
            LSU_RESP: begin
                mem_resp_ready_o = lsu_resp_ready_i;
                lsu_resp_valid_o = mem_resp_valid_i;
                lsu_rdata_o      = mem_rdata_i;
                if (mem_resp_valid_i && lsu_resp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A transaction table
// drives single-requester traffic with configurable memory/requester stalls;
// hand-written sequences cover reset, contention and reset mid-transaction.
// A monitor pops expected memory requests/responses from scoreboard queues
// whenever a handshake happens.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid_i, ifu_req_ready_o;
    logic [31:0] ifu_addr_i;
    logic        ifu_resp_valid_o, ifu_resp_ready_i;
    logic [31:0] ifu_rdata_o;
    logic        lsu_req_valid_i, lsu_req_ready_o;
    logic [31:0] lsu_addr_i;
    logic        lsu_wen_i;
    logic [31:0] lsu_wdata_i;
    logic [3:0]  lsu_wmask_i;
    logic        lsu_resp_valid_o, lsu_resp_ready_i;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_valid_o, mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_resp_valid_i, mem_resp_ready_o;
    logic [31:0] mem_rdata_i;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
        .ifu_addr_i(ifu_addr_i),
        .ifu_resp_valid_o(ifu_resp_valid_o), .ifu_resp_ready_i(ifu_resp_ready_i),
        .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_addr_i(lsu_addr_i), .lsu_wen_i(lsu_wen_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_wmask_i(lsu_wmask_i),
        .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_ready_i(lsu_resp_ready_i),
        .lsu_rdata_o(lsu_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mreq_t;

    typedef struct {
        logic        lsu;
        logic [31:0] rdata;
    } mresp_t;

    // One table row: requester inputs, memory behaviour, expected memory fields.
    typedef struct {
        logic        lsu;
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        int          req_wait;
        int          resp_wait;
        int          rr_wait;
        logic        exp_wen;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wmask;
    } txn_t;

    mreq_t  req_q[$];
    mresp_t resp_q[$];
    int     errors = 0;
    int     checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic any_out();
        return |{ifu_req_ready_o, ifu_resp_valid_o, ifu_rdata_o,
                 lsu_req_ready_o, lsu_resp_valid_o, lsu_rdata_o,
                 mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o,
                 mem_wmask_o, mem_resp_ready_o};
    endfunction

    task automatic push_exp(input logic lsu, input logic [31:0] addr, input logic wen,
                            input logic [31:0] wdata, input logic [3:0] wmask,
                            input logic [31:0] rdata);
        mreq_t  r;
        mresp_t s;
        r.lsu = lsu; r.addr = addr; r.wen = wen; r.wdata = wdata; r.wmask = wmask;
        s.lsu = lsu; s.rdata = rdata;
        req_q.push_back(r);
        resp_q.push_back(s);
    endtask

    task automatic clear_inputs();
        ifu_req_valid_i = 0; ifu_addr_i = 0; ifu_resp_ready_i = 0;
        lsu_req_valid_i = 0; lsu_addr_i = 0; lsu_wen_i = 0;
        lsu_wdata_i = 0; lsu_wmask_i = 0; lsu_resp_ready_i = 0;
        mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_rdata_i = 0;
    endtask

    // Scoreboard monitor: inputs settle by negedge+1, handshakes fire on the
    // following posedge.
    always @(negedge clock) begin : monitor
        mreq_t  e;
        mresp_t s;
        #2;
        if (!reset) begin
            if (mem_req_valid_o && mem_req_ready_i) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected: got addr %h expected no request", mem_addr_o);
                end else begin
                    e = req_q.pop_front();
                    check("grant_lsu", lsu_req_ready_o, e.lsu);
                    check("grant_ifu", ifu_req_ready_o, !e.lsu);
                    check("mem_addr", mem_addr_o, e.addr);
                    check("mem_wen", mem_wen_o, e.wen);
                    check("mem_wdata", mem_wdata_o, e.wdata);
                    check("mem_wmask", mem_wmask_o, e.wmask);
                end
            end
            if (mem_resp_valid_i && mem_resp_ready_o) begin
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_unexpected: got rdata %h expected no response", mem_rdata_i);
                end else begin
                    s = resp_q.pop_front();
                    check("resp_lsu", lsu_resp_valid_o, s.lsu);
                    check("resp_ifu", ifu_resp_valid_o, !s.lsu);
                    check("resp_rdata", s.lsu ? lsu_rdata_o : ifu_rdata_o, s.rdata);
                end
            end
        end
    end

    task automatic run_txn(input txn_t t);
        int rq = t.req_wait;
        int rs = t.resp_wait;
        int rr = t.rr_wait;
        bit done;
        @(negedge clock);
        ifu_addr_i  = t.lsu ? ~t.addr : t.addr;
        lsu_addr_i  = t.lsu ? t.addr : ~t.addr;
        lsu_wen_i   = t.wen;
        lsu_wdata_i = t.wdata;
        lsu_wmask_i = t.wmask;
        ifu_req_valid_i  = !t.lsu;
        lsu_req_valid_i  = t.lsu;
        ifu_resp_ready_i = 1;
        lsu_resp_ready_i = 1;
        mem_req_ready_i  = 0;
        mem_resp_valid_i = 1;   // stray response; must be ignored until RESP
        mem_rdata_i      = t.rdata;
        push_exp(t.lsu, t.addr, t.exp_wen, t.exp_wdata, t.exp_wmask, t.rdata);
        #1;
        check("idle_mem_req_valid", mem_req_valid_o, 0);
        check("idle_mem_resp_ready", mem_resp_ready_o, 0);

        done = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clock);
            check("req_mem_req_valid", mem_req_valid_o, 1);
            mem_req_ready_i = (rq == 0);
            if (rq > 0) rq--; else done = 1;
            #1;
            check("req_ready_owner", t.lsu ? lsu_req_ready_o : ifu_req_ready_o, mem_req_ready_i);
            check("req_ready_other", t.lsu ? ifu_req_ready_o : lsu_req_ready_o, 0);
            check("req_stray_resp", {mem_resp_ready_o, ifu_resp_valid_o, lsu_resp_valid_o}, 0);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL req_timeout: got no acceptance expected within 40 cycles");
        end

        done = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clock);
            if (cyc == 0) begin
                ifu_req_valid_i = 0;
                lsu_req_valid_i = 0;
                mem_req_ready_i = 0;
            end
            mem_resp_valid_i = (rs == 0);
            if (t.lsu) lsu_resp_ready_i = (rr == 0);
            else       ifu_resp_ready_i = (rr == 0);
            if (rs > 0) rs--;
            if (rr > 0) rr--;
            #1;
            check("resp_valid_owner", t.lsu ? lsu_resp_valid_o : ifu_resp_valid_o, mem_resp_valid_i);
            check("resp_valid_other", t.lsu ? ifu_resp_valid_o : lsu_resp_valid_o, 0);
            check("resp_rdata_other", t.lsu ? ifu_rdata_o : lsu_rdata_o, 0);
            check("mem_resp_ready", mem_resp_ready_o, t.lsu ? lsu_resp_ready_i : ifu_resp_ready_i);
            check("resp_mem_req_valid", mem_req_valid_o, 0);
            if (mem_resp_valid_i && mem_resp_ready_o) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got no response handshake expected within 40 cycles");
        end

        // Back in IDLE with the memory still showing valid: no second transfer.
        @(negedge clock);
        #1;
        check("post_resp_no_dup", {ifu_resp_valid_o, lsu_resp_valid_o, mem_resp_ready_o}, 0);
        mem_resp_valid_i = 0;
    endtask

    txn_t tbl[6];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got time limit expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b0, 32'h80000000, 1'b1, 32'hFFFF0000, 4'hA, 32'h00000413, 0, 0, 0, 1'b0, 32'h0, 4'h0};
        tbl[1] = '{1'b1, 32'h80001000, 1'b1, 32'hDEADBEEF, 4'hF, 32'h12345678, 0, 0, 0, 1'b1, 32'hDEADBEEF, 4'hF};
        tbl[2] = '{1'b0, 32'h80000004, 1'b1, 32'h13579BDF, 4'h5, 32'hCAFEF00D, 3, 2, 1, 1'b0, 32'h0, 4'h0};
        tbl[3] = '{1'b1, 32'h80002000, 1'b0, 32'h55AA55AA, 4'h3, 32'h0BADF00D, 1, 1, 1, 1'b0, 32'h55AA55AA, 4'h3};
        tbl[4] = '{1'b1, 32'h80002008, 1'b1, 32'h01020304, 4'h6, 32'h00000000, 0, 3, 0, 1'b1, 32'h01020304, 4'h6};
        tbl[5] = '{1'b0, 32'hFFFFFFFC, 1'b0, 32'h0, 4'h0, 32'hFFFFFFFF, 2, 0, 2, 1'b0, 32'h0, 4'h0};

        // Reset held with a request pending, then released idle for 10 cycles.
        clear_inputs();
        reset = 1;
        ifu_req_valid_i = 1;
        @(negedge clock);
        #1 check("reset_outs_zero", any_out(), 0);
        ifu_req_valid_i = 0;
        @(negedge clock);
        reset = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1 check("idle_outs_zero", any_out(), 0);
        end

        for (int i = 0; i < 6; i++) run_txn(tbl[i]);

        // Contention right after reset: both requesters held valid for
        // four transactions; expected grant order IFU, LSU, IFU, LSU.
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        @(negedge clock);
        ifu_addr_i = 32'h80000100;
        lsu_addr_i = 32'h80003000;
        lsu_wen_i = 0; lsu_wdata_i = 0; lsu_wmask_i = 0;
        ifu_resp_ready_i = 1; lsu_resp_ready_i = 1;
        mem_req_ready_i = 1; mem_resp_valid_i = 1; mem_rdata_i = 32'h600DD00D;
        for (int i = 0; i < 2; i++) begin
            push_exp(1'b0, 32'h80000100, 1'b0, 32'h0, 4'h0, 32'h600DD00D);
            push_exp(1'b1, 32'h80003000, 1'b0, 32'h0, 4'h0, 32'h600DD00D);
        end
        ifu_req_valid_i = 1;
        lsu_req_valid_i = 1;
        repeat (11) @(negedge clock);
        ifu_req_valid_i = 0;
        lsu_req_valid_i = 0;
        @(negedge clock);
        #1 check("contention_end_idle", any_out(), 0);
        check("contention_req_q_empty", req_q.size(), 0);
        check("contention_resp_q_empty", resp_q.size(), 0);
        clear_inputs();

        // Async reset while the LSU owns the response phase.
        @(negedge clock);
        lsu_addr_i = 32'h80004000; lsu_wen_i = 1;
        lsu_wdata_i = 32'hA5A5A5A5; lsu_wmask_i = 4'hF;
        lsu_req_valid_i = 1;
        begin
            mreq_t r;
            r.lsu = 1; r.addr = 32'h80004000; r.wen = 1; r.wdata = 32'hA5A5A5A5; r.wmask = 4'hF;
            req_q.push_back(r);
        end
        @(negedge clock);
        mem_req_ready_i = 1;
        @(negedge clock);
        lsu_req_valid_i = 0; mem_req_ready_i = 0;
        mem_resp_valid_i = 0; lsu_resp_ready_i = 1;
        #1 check("midreset_in_resp", mem_resp_ready_o, 1);
        #2 reset = 1;
        #1 check("midreset_outs_zero", any_out(), 0);
        clear_inputs();
        @(negedge clock);
        reset = 0;
        run_txn(tbl[0]);
        check("final_req_q_empty", req_q.size(), 0);
        check("final_resp_q_empty", resp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory request/response port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between the pipeline front/back ends and the memory interface.
- Uses the same valid/ready handshake as the pipeline stage controllers.
- Serves one transaction at a time; round-robin when both requesters contend.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; mask width is DATA_W/8

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ifu_req_valid_i  in  1  IFU read request valid
ifu_req_ready_o  out  1  IFU request accepted
ifu_addr_i  in  ADDR_W  IFU read address
ifu_resp_valid_o  out  1  IFU read data valid
ifu_resp_ready_i  in  1  IFU can take read data
ifu_rdata_o  out  DATA_W  IFU read data
lsu_req_valid_i  in  1  LSU request valid
lsu_req_ready_o  out  1  LSU request accepted
lsu_addr_i  in  ADDR_W  LSU address
lsu_wen_i  in  1  1 = write, 0 = read
lsu_wdata_i  in  DATA_W  LSU write data
lsu_wmask_i  in  DATA_W/8  LSU byte write mask
lsu_resp_valid_o  out  1  LSU response valid (read data or write ack)
lsu_resp_ready_i  in  1  LSU can take response
lsu_rdata_o  out  DATA_W  LSU read data
mem_req_valid_o  out  1  memory request valid
mem_req_ready_i  in  1  memory accepts request
mem_addr_o  out  ADDR_W  memory address
mem_wen_o  out  1  memory write enable
mem_wdata_o  out  DATA_W  memory write data
mem_wmask_o  out  DATA_W/8  memory byte mask
mem_resp_valid_i  in  1  memory response valid
mem_resp_ready_o  out  1  arbiter accepts response
mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is asynchronous and active-high.
- Reset state:
  - state = IDLE; last_grant = LSU, so the IFU wins the first tie.
  - All valid/ready outputs are 0; all data/address outputs are 0.
- States: IDLE, IFU_REQ, IFU_RESP, LSU_REQ, LSU_RESP.
- IDLE:
  - All handshake outputs are 0.
  - Only one requester valid: that requester is granted; next state is <X>_REQ.
  - Both valid: grant the requester opposite to last_grant; update last_grant to the granted requester.
  - Neither valid: stay in IDLE.
- X_REQ:
  - mem_req_valid_o = 1.
  - mem_addr/wen/wdata/wmask_o are driven combinationally from the granted requester.
  - IFU: wen = 0, wmask = 0, wdata = 0.
  - x_req_ready_o = mem_req_ready_i.
  - When mem_req_valid_o && mem_req_ready_i: go to X_RESP.
- X_RESP:
  - mem_resp_ready_o = x_resp_ready_i.
  - x_resp_valid_o = mem_resp_valid_i.
  - x_rdata_o = mem_rdata_i.
  - When mem_resp_valid_i && mem_resp_ready_o: go to IDLE.
- Routing outside the owning state:
  - Non-granted requester: ready/valid = 0, rdata = 0.
  - mem_resp_ready_o = 0 outside X_RESP. A stray mem_resp_valid_i there is ignored and not forwarded.
- Requester rule: address, data and control must stay stable while req_valid is high and unaccepted. The arbiter does not latch them; they are routed combinationally.
- A requester dropping valid in X_REQ before acceptance is a protocol violation; behaviour is undefined.
- Latency: minimum 3 cycles from req_valid to resp_valid on a zero-wait memory (IDLE, REQ, RESP). Back-to-back transactions return through IDLE, giving one bubble cycle.
- Fairness: under sustained contention grants alternate IFU, LSU, IFU, ... Neither requester waits more than one foreign transaction.
- Writes: the LSU write response handshake completes exactly like a read. lsu_rdata_o carries whatever mem_rdata_i presents.
- Reset mid-transaction: forces IDLE immediately and drops all outputs. The memory side must be reset in the same cycle.

Test Plan:
- Reset held, then released with no requests: all outputs 0; state stays IDLE for 10 cycles.
- IFU read addr 0x80000000, zero-wait memory returns 0x00000413: mem_req_valid_o seen on cycle 2; ifu_resp_valid_o with rdata 0x00000413 on cycle 3; lsu_* outputs stay 0.
- LSU write addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF: mem_wen_o = 1 and mem outputs match during LSU_REQ; lsu_resp_valid_o pulses once.
- Both valid in the same cycle after reset, held for 4 transactions: grant order IFU, LSU, IFU, LSU.
- Memory stalls 3 cycles on req_ready and 2 cycles on resp_valid, and IFU holds resp_ready low for 1 cycle: no duplicate handshakes; single data transfer with correct rdata.
- Async reset asserted mid-LSU_RESP: all outputs 0 within the same cycle; the next request after release is served normally.
